// File: rtl/tlul_host_port.sv
// Single-outstanding TL-UL initiator: host request port to Get/Put, D result back to host.
// Optional D-channel timeout and late-beat draining with `define TLH_TIMEOUT_EN.
module tlul_host_port #(
  parameter int TL_RS   = 4,
  parameter int TL_SZ   = 4,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             tlh_clock_i,
  input  logic             tlh_reset_i,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [AW-1:0]    req_address,
  input  logic [3:0]       req_mask,
  input  logic [31:0]      req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_error,
  output logic [2:0]       tlh_a_opcode,
  output logic [2:0]       tlh_a_param,
  output logic [TL_SZ-1:0] tlh_a_size,
  output logic [TL_RS-1:0] tlh_a_source,
  output logic [AW-1:0]    tlh_a_address,
  output logic [3:0]       tlh_a_mask,
  output logic [31:0]      tlh_a_data,
  output logic             tlh_a_corrupt,
  output logic             tlh_a_valid,
  input  logic             tlh_a_ready,
  input  logic [2:0]       tlh_d_opcode,
  input  logic [1:0]       tlh_d_param,
  input  logic [TL_SZ-1:0] tlh_d_size,
  input  logic [TL_RS-1:0] tlh_d_source,
  input  logic             tlh_d_denied,
  input  logic [31:0]      tlh_d_data,
  input  logic             tlh_d_corrupt,
  input  logic             tlh_d_valid,
  output logic             tlh_d_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q;
  logic [TL_SZ-1:0] size_q;
  logic [AW-1:0]    addr_q;
  logic [3:0]       mask_q;
  logic [31:0]      data_q;
  logic [TL_RS-1:0] src_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic             req_hs, a_hs, d_hs, rd, d_err, tmo;
  logic             unused_d;

  assign unused_d = ^{tlh_d_param, tlh_d_size};

  assign req_ready     = state_q == S_IDLE;
  assign tlh_a_valid   = state_q == S_ADDR;
  assign rsp_valid     = state_q == S_DONE;
  assign tlh_a_opcode  = op_q;
  assign tlh_a_param   = 3'd0;
  assign tlh_a_size    = size_q;
  assign tlh_a_source  = src_q;
  assign tlh_a_address = addr_q;
  assign tlh_a_mask    = mask_q;
  assign tlh_a_data    = data_q;
  assign tlh_a_corrupt = 1'b0;
  assign rsp_data      = rdata_q;
  assign rsp_error     = err_q;

  assign req_hs = req_valid && state_q == S_IDLE;
  assign a_hs   = tlh_a_valid && tlh_a_ready;
  assign d_hs   = tlh_d_valid && state_q == S_RESP;
  assign rd     = op_q == 3'd4;

  // The counter has already advanced past the issued source by RESP.
  assign d_err = tlh_d_denied | tlh_d_corrupt
               | (tlh_d_source != (src_q - TL_RS'(1)))
               | (tlh_d_opcode != {2'b00, rd});

`ifdef TLH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_q;

  assign tmo = state_q == S_RESP && !tlh_d_valid
            && tmo_q == CW'(TIMEOUT - 1);
  // Open outside ADDR so late beats are drained rather than stalled.
  assign tlh_d_ready = state_q != S_ADDR;

  always_ff @(posedge tlh_clock_i) begin
    if (tlh_reset_i || state_q != S_RESP) tmo_q <= '0;
    else if (!tmo) tmo_q <= tmo_q + CW'(1);
  end
`else
  localparam int unused_tmo = TIMEOUT;
  assign tmo         = 1'b0;
  assign tlh_d_ready = state_q == S_RESP;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req_valid) state_d = S_ADDR;
      S_ADDR: if (tlh_a_ready) state_d = S_RESP;
      S_RESP: if (tlh_d_valid || tmo) state_d = S_DONE;
      S_DONE: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge tlh_clock_i) begin
    if (tlh_reset_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      size_q  <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      src_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        op_q   <= !req_write ? 3'd4 : (req_mask == 4'hF ? 3'd0 : 3'd1);
        size_q <= TL_SZ'(2);
        addr_q <= {req_address[AW-1:2], 2'b00};
        mask_q <= req_write ? req_mask : 4'hF;
        data_q <= req_data;
      end
      if (a_hs) src_q <= src_q + TL_RS'(1);
      if (d_hs) begin
        err_q   <= d_err;
        rdata_q <= (rd && !d_err) ? tlh_d_data : 32'h0;
      end else if (tmo) begin
        err_q   <= 1'b1;
        rdata_q <= 32'h0;
      end
    end
  end

endmodule
